spi_slave_ctrl: RTL
===================

# spi_slave_ctrl

- Sequences the single-port command RAM from the SPI pins.
- Deserialises MOSI frames into 10-bit command words: bits [9:8] are the opcode, bits [7:0] the address or data.
- Presents each word to the RAM on `rx_data`/`rx_valid`.
- Serialises the RAM's 8-bit read result back out on MISO.
- Sits between the chip pins and `ram` in the SPI top level, and tracks whether a read address has been loaded so read frames are routed correctly.

## Interface
- `RX_W`, 10, command word width; only the default is verified.
- `TX_W`, 8, read-data width; only the default is verified.
- `clk`  in  1  system clock; also the SPI bit clock, all sampling on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `SS_n`  in  1  slave select, active low; high terminates or aborts the frame.
- `MOSI`  in  1  serial data in, MSB first.
- `MISO`  out  1  serial data out, MSB first.
- `rx_data`  out  RX_W  assembled command word to the RAM `din`.
- `rx_valid`  out  1  one-cycle strobe qualifying `rx_data`.
- `tx_data`  in  TX_W  RAM read data (`dout`).
- `tx_valid`  in  1  RAM read-data valid.

## Operation
- States:
  - `IDLE`
  - `CHK_CMD`
  - `WRITE`
  - `READ_ADD`
  - `READ_DATA`
  - `SEND`
- Internal state:
  - 4-bit bit counter
  - `rd_addr_ok` flag
  - TX_W shift register
- `IDLE`: on `SS_n`=0 go to `CHK_CMD`; MOSI is ignored on this edge.
- `CHK_CMD`: sample MOSI as `rx_data[9]` and go to the operation state:
  - MOSI=0 -> `WRITE`.
  - MOSI=1 and `rd_addr_ok`=0 -> `READ_ADD`.
  - MOSI=1 and `rd_addr_ok`=1 -> `READ_DATA`.
- `WRITE`, `READ_ADD`, `READ_DATA`:
  - Shift in 9 more bits (`rx_data[8]` down to `[0]`), one per edge.
  - On the 9th bit, assert `rx_valid` for exactly one cycle with the full word.
  - The opcode is forwarded unmodified; the RAM decodes it.
- After the word in `WRITE`: hold in the state, ignore MOSI, wait for `SS_n`=1.
- After the word in `READ_ADD`: set `rd_addr_ok`, hold, wait for `SS_n`=1.
- After the word in `READ_DATA`:
  - Clear `rd_addr_ok`.
  - Wait, with no timeout, for `tx_valid`=1.
  - On the edge that samples it, load `tx_data` into the shift register and enter `SEND`.
- `SEND`:
  - MISO = shift register MSB.
  - Shift left once per edge for TX_W bits.
  - Then MISO=0 and hold until `SS_n`=1.
- `tx_valid` seen in any state other than post-word `READ_DATA` is ignored.
- `SS_n`=1 in any non-IDLE state -> `IDLE` on that edge:
  - The bit counter clears.
  - A partial word is discarded with no `rx_valid`.
  - `rd_addr_ok` changes only on a completed word.
  - A partially shifted MISO byte is dropped.
- `rx_data` holds its last value between strobes.

## Timing
- Reset (async assert, sync-safe deassert) gives:
  - state `IDLE`
  - `MISO`=0
  - `rx_valid`=0
  - `rx_data`=0
  - bit counter 0
  - `rd_addr_ok`=0
  - shift register 0
- Edges are counted from the first rising edge sampling `SS_n`=0:
  - E1: `IDLE`->`CHK_CMD`.
  - E2: bit 9 sampled.
  - E3..E11: bits 8..0 sampled.
  - `rx_valid`=1 in the cycle after E11 only.
- Write/read-address frame: 11 edges minimum of `SS_n` low; an extra edge is harmless.
- Read-data frame with `ram` (`tx_valid` registered 1 cycle after `rx_valid`):
  - `tx_valid` is sampled at E13.
  - MISO bit 7 is valid after E13, bit 0 after E20.
  - MISO returns to 0 after E21.
- Each MISO bit is stable for one full `clk` period; the master samples on the following rising edge.
- `rx_valid` never asserts on two consecutive cycles.
- `rx_valid` never asserts within a frame aborted before E11.
- Reset mid-frame: all outputs return to reset values immediately; `rd_addr_ok` is lost.

## Test plan
- Write path: reset 8 ns; frame MOSI=`00_0000_0111`, then frame `01_0000_0011` -> two single-cycle `rx_valid` pulses with `rx_data`=0x007 and 0x103; MISO stays 0.
- Read path with `ram` attached, continuing from the write path: frame `10_0000_0111`, then frame `11_0000_0000` -> `rx_valid` with 0x207, then 0x300; MISO shifts 0x03 (00000011) MSB first on E13..E20.
- Read flag routing: a second `1x` frame after a completed `READ_DATA` goes to `READ_ADD` (`rd_addr_ok` was cleared) -> `rx_valid` with the word; no MISO activity.
- Abort: raise `SS_n` after E7 of a write frame -> no `rx_valid`; state `IDLE` next edge; the next full frame 0x0AA is captured correctly.
- Abort in `SEND`: raise `SS_n` after 3 MISO bits -> MISO=0 next edge; `rd_addr_ok`=0; the next `1x` frame is treated as a read address.
- Async reset mid-`READ_ADD` (`reset_n` low between edges) -> outputs 0 without a clock edge; the following `1x` frame goes to `READ_ADD`.

Source files
------------

// File: rtl/spi_slave_ctrl.sv
// SPI slave sequencer for the command RAM: deserialises 10-bit command frames from MOSI
// and serialises the RAM's read byte back out on MISO, tracking whether a read address is loaded.
module spi_slave_ctrl #(
    parameter int RX_W = 10,
    parameter int TX_W = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            SS_n,
    input  logic            MOSI,
    output logic            MISO,
    output logic [RX_W-1:0] rx_data,
    output logic            rx_valid,
    input  logic [TX_W-1:0] tx_data,
    input  logic            tx_valid
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] CHK_CMD   = 3'd1;
    localparam logic [2:0] WRITE     = 3'd2;
    localparam logic [2:0] READ_ADD  = 3'd3;
    localparam logic [2:0] READ_DATA = 3'd4;
    localparam logic [2:0] SEND      = 3'd5;

    // Bit counter values: LAST_BIT marks the edge sampling bit 0, WORD_DONE the post-word hold.
    localparam logic [3:0] LAST_BIT  = 4'(RX_W - 2);
    localparam logic [3:0] WORD_DONE = 4'(RX_W - 1);
    localparam logic [3:0] TX_BITS   = 4'(TX_W);

    logic [2:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            rd_addr_ok_q, rd_addr_ok_d;
    logic [TX_W-1:0] shreg_q, shreg_d;
    logic [RX_W-2:0] rx_shift_q, rx_shift_d;
    logic [RX_W-1:0] rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_addr_ok_d = rd_addr_ok_q;
        shreg_d      = shreg_q;
        rx_shift_d   = rx_shift_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;

        if (state_q != IDLE && SS_n) begin
            // Frame end or abort: partial word and partial MISO byte are dropped.
            state_d    = IDLE;
            cnt_d      = 4'd0;
            shreg_d    = '0;
            rx_shift_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = 4'd0;
                    if (!SS_n) begin
                        state_d = CHK_CMD;
                    end
                end
                CHK_CMD: begin
                    rx_shift_d = {rx_shift_q[RX_W-3:0], MOSI};
                    cnt_d      = 4'd0;
                    if (!MOSI) begin
                        state_d = WRITE;
                    end else if (rd_addr_ok_q) begin
                        state_d = READ_DATA;
                    end else begin
                        state_d = READ_ADD;
                    end
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (cnt_q < LAST_BIT) begin
                        rx_shift_d = {rx_shift_q[RX_W-3:0], MOSI};
                        cnt_d      = cnt_q + 4'd1;
                    end else if (cnt_q == LAST_BIT) begin
                        rx_data_d  = {rx_shift_q, MOSI};
                        rx_valid_d = 1'b1;
                        cnt_d      = WORD_DONE;
                        if (state_q == READ_ADD) begin
                            rd_addr_ok_d = 1'b1;
                        end else if (state_q == READ_DATA) begin
                            rd_addr_ok_d = 1'b0;
                        end
                    end else if (state_q == READ_DATA && tx_valid) begin
                        shreg_d = tx_data;
                        cnt_d   = 4'd0;
                        state_d = SEND;
                    end
                end
                SEND: begin
                    // Zeros shift in behind the data, so MISO settles to 0 after the last bit.
                    if (cnt_q < TX_BITS) begin
                        shreg_d = {shreg_q[TX_W-2:0], 1'b0};
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            rd_addr_ok_q <= 1'b0;
            shreg_q      <= '0;
            rx_shift_q   <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_addr_ok_q <= rd_addr_ok_d;
            shreg_q      <= shreg_d;
            rx_shift_q   <= rx_shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
        end
    end

    // rx_valid is a bare strobe (no ready): the RAM must take rx_data in that one cycle.
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign MISO     = (state_q == SEND) & shreg_q[TX_W-1];

endmodule
